// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the dot-product MAC sequencer.
// The drain counter is sized for the largest supported memory and MAC latencies.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FETCH   = 3'd2,
        DRAIN   = 3'd3,
        CAPTURE = 3'd4
    } ctrlState_e;

    localparam int MAX_MEM_LATENCY = 4;
    localparam int MAX_MAC_LATENCY = 4;
    // Holds counts 0..MEM_LATENCY+MAC_LATENCY, i.e. MEM_LATENCY+1+MAC_LATENCY drain cycles
    localparam int DRAIN_CNT_W = $clog2(MAX_MEM_LATENCY + MAX_MAC_LATENCY + 1 + 1);

endpackage

// File: rtl/mac_addr_gen.sv
// Linear read-address generator: element index plus base-relative A/B addresses.
// Addresses are registered and wrap modulo 2^ADDR_W.
module mac_addr_gen #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              last
);

    localparam logic [LEN_W-1:0] IDX_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [LEN_W-1:0]  idxR;
    logic [LEN_W-1:0]  idxNextS;
    logic [ADDR_W-1:0] baseAR;
    logic [ADDR_W-1:0] baseBR;
    logic [ADDR_W-1:0] addrAR;
    logic [ADDR_W-1:0] addrBR;

    // Next element index
    always_comb begin
        idxNextS = idxR + IDX_ONE;
    end

    // Index counter, latched bases and registered addresses
    always_ff @(posedge clk) begin
        if (reset) begin
            idxR   <= {LEN_W{1'b0}};
            baseAR <= {ADDR_W{1'b0}};
            baseBR <= {ADDR_W{1'b0}};
            addrAR <= {ADDR_W{1'b0}};
            addrBR <= {ADDR_W{1'b0}};
        end else if (load) begin
            idxR   <= {LEN_W{1'b0}};
            baseAR <= base_a;
            baseBR <= base_b;
            addrAR <= base_a;
            addrBR <= base_b;
        end else if (advance) begin
            idxR   <= idxNextS;
            addrAR <= baseAR + ADDR_W'(idxNextS);
            addrBR <= baseBR + ADDR_W'(idxNextS);
        end else begin
            idxR   <= idxR;
            baseAR <= baseAR;
            baseBR <= baseBR;
            addrAR <= addrAR;
            addrBR <= addrBR;
        end
    end

    assign addr_a = addrAR;
    assign addr_b = addrBR;
    assign last   = (idxR == (len - IDX_ONE));

endmodule

// File: rtl/mac_dot_product_ctrl.sv
// Dot-product sequencer: clears an external MAC, streams len operand pairs from two
// memories into it with an aligned valid strobe, then captures the accumulated result.
module mac_dot_product_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int bitwidthA      = 8,
    parameter int bitwidthB      = 8,
    parameter int bitwidthAccRes = 25,
    parameter int ADDR_W         = 9,
    parameter int LEN_W          = 9,
    parameter int MEM_LATENCY    = 1,
    parameter int MAC_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          vec_len,
    input  logic [ADDR_W-1:0]         base_addr_a,
    input  logic [ADDR_W-1:0]         base_addr_b,
    output logic                      busy,
    output logic                      done,
    output logic [bitwidthAccRes-1:0] result,
    output logic                      result_valid,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr_a,
    output logic [ADDR_W-1:0]         mem_addr_b,
    input  logic [bitwidthA-1:0]      mem_data_a,
    input  logic [bitwidthB-1:0]      mem_data_b,
    output logic                      mac_clear,
    output logic                      mac_valid,
    output logic [bitwidthA-1:0]      mac_a,
    output logic [bitwidthB-1:0]      mac_b,
    input  logic [bitwidthAccRes-1:0] mac_result
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = {{(DRAIN_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(MEM_LATENCY + MAC_LATENCY);

    ctrlState_e                stateR;
    ctrlState_e                nextStateS;
    logic [LEN_W-1:0]          lenR;
    logic [DRAIN_CNT_W-1:0]    drainCntR;
    logic                      loadS;
    logic                      advanceS;
    logic                      lastS;
    logic [ADDR_W-1:0]         addrAS;
    logic [ADDR_W-1:0]         addrBS;

    logic                      busyR;
    logic                      doneR;
    logic [bitwidthAccRes-1:0] resultR;
    logic                      resultValidR;
    logic                      memRdEnR;
    logic                      macClearR;
    logic [MEM_LATENCY:0]      validPipeR;
    logic [bitwidthA-1:0]      macAR;
    logic [bitwidthB-1:0]      macBR;

    mac_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addrGen (
        .clk     (clk),
        .reset   (reset),
        .load    (loadS),
        .advance (advanceS),
        .base_a  (base_addr_a),
        .base_b  (base_addr_b),
        .len     (lenR),
        .addr_a  (addrAS),
        .addr_b  (addrBS),
        .last    (lastS)
    );

    // Next-state decode; a start coinciding with done is refused so done stays a clean pulse
    always_comb begin
        nextStateS = stateR;
        loadS      = 1'b0;
        advanceS   = 1'b0;
        case (stateR)
            IDLE: begin
                if (start && !doneR) begin
                    loadS      = 1'b1;
                    nextStateS = CLEAR;
                end else begin
                    nextStateS = IDLE;
                end
            end
            CLEAR: begin
                if (lenR == {LEN_W{1'b0}}) begin
                    nextStateS = CAPTURE;
                end else begin
                    nextStateS = FETCH;
                end
            end
            FETCH: begin
                advanceS = 1'b1;
                if (lastS) begin
                    nextStateS = DRAIN;
                end else begin
                    nextStateS = FETCH;
                end
            end
            DRAIN: begin
                if (drainCntR == DRAIN_LAST) begin
                    nextStateS = CAPTURE;
                end else begin
                    nextStateS = DRAIN;
                end
            end
            CAPTURE: begin
                nextStateS = IDLE;
            end
            default: begin
                nextStateS = IDLE;
            end
        endcase
    end

    // State register, latched length and drain counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stateR    <= IDLE;
            lenR      <= {LEN_W{1'b0}};
            drainCntR <= {DRAIN_CNT_W{1'b0}};
        end else begin
            stateR    <= nextStateS;
            lenR      <= loadS ? vec_len : lenR;
            drainCntR <= (stateR == DRAIN) ? (drainCntR + DRAIN_ONE) : {DRAIN_CNT_W{1'b0}};
        end
    end

    // Control outputs registered from the next state so they line up with the state itself
    always_ff @(posedge clk) begin
        if (reset) begin
            busyR     <= 1'b0;
            memRdEnR  <= 1'b0;
            macClearR <= 1'b0;
            doneR     <= 1'b0;
        end else begin
            busyR     <= (nextStateS != IDLE);
            memRdEnR  <= (nextStateS == FETCH);
            macClearR <= (nextStateS == CLEAR);
            doneR     <= (stateR == CAPTURE);
        end
    end

    // Result capture; result_valid drops only when a new operation is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            resultR      <= {bitwidthAccRes{1'b0}};
            resultValidR <= 1'b0;
        end else if (loadS) begin
            resultR      <= resultR;
            resultValidR <= 1'b0;
        end else if (stateR == CAPTURE) begin
            resultR      <= mac_result;
            resultValidR <= 1'b1;
        end else begin
            resultR      <= resultR;
            resultValidR <= resultValidR;
        end
    end

    // Valid delay line; operands are registered the cycle before their valid reaches the MAC
    always_ff @(posedge clk) begin
        if (reset) begin
            validPipeR <= {(MEM_LATENCY+1){1'b0}};
            macAR      <= {bitwidthA{1'b0}};
            macBR      <= {bitwidthB{1'b0}};
        end else begin
            validPipeR <= {validPipeR[MEM_LATENCY-1:0], memRdEnR};
            if (validPipeR[MEM_LATENCY-1]) begin
                macAR <= mem_data_a;
                macBR <= mem_data_b;
            end else begin
                macAR <= macAR;
                macBR <= macBR;
            end
        end
    end

    assign busy         = busyR;
    assign done         = doneR;
    assign result       = resultR;
    assign result_valid = resultValidR;
    assign mem_rd_en    = memRdEnR;
    assign mem_addr_a   = addrAS;
    assign mem_addr_b   = addrBS;
    assign mac_clear    = macClearR;
    assign mac_valid    = validPipeR[MEM_LATENCY];
    assign mac_a        = macAR;
    assign mac_b        = macBR;

endmodule

// File: tb/tb_mac_dot_product_ctrl.sv
// Randomized self-checking bench: behavioural memories and MAC around the sequencer,
// expectations derived from the dot-product definition and the documented latency.
module tb_mac_dot_product_ctrl;

    localparam int BW_A    = 8;
    localparam int BW_B    = 8;
    localparam int BW_ACC  = 25;
    localparam int ADDR_W  = 9;
    localparam int LEN_W   = 9;
    localparam int MEM_LAT = 1;
    localparam int MAC_LAT = 1;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic [ADDR_W-1:0] base_addr_a;
    logic [ADDR_W-1:0] base_addr_b;
    logic              busy;
    logic              done;
    logic [BW_ACC-1:0] result;
    logic              result_valid;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [BW_A-1:0]   mem_data_a;
    logic [BW_B-1:0]   mem_data_b;
    logic              mac_clear;
    logic              mac_valid;
    logic [BW_A-1:0]   mac_a;
    logic [BW_B-1:0]   mac_b;
    logic [BW_ACC-1:0] mac_result;

    logic [BW_A-1:0]   memA [DEPTH];
    logic [BW_B-1:0]   memB [DEPTH];
    logic [BW_A-1:0]   rdA;
    logic [BW_B-1:0]   rdB;
    logic [BW_ACC-1:0] acc;

    int cyc = 0;
    int errCnt = 0;
    int chkCnt = 0;
    int rdCnt = 0;
    int vldCnt = 0;
    int vldRuns = 0;
    int clrCnt = 0;
    int doneCnt = 0;
    logic [ADDR_W-1:0] addrQA [$];
    logic [ADDR_W-1:0] addrQB [$];

    mac_dot_product_ctrl #(
        .bitwidthA      (BW_A),
        .bitwidthB      (BW_B),
        .bitwidthAccRes (BW_ACC),
        .ADDR_W         (ADDR_W),
        .LEN_W          (LEN_W),
        .MEM_LATENCY    (MEM_LAT),
        .MAC_LATENCY    (MAC_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .vec_len      (vec_len),
        .base_addr_a  (base_addr_a),
        .base_addr_b  (base_addr_b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .mem_rd_en    (mem_rd_en),
        .mem_addr_a   (mem_addr_a),
        .mem_addr_b   (mem_addr_b),
        .mem_data_a   (mem_data_a),
        .mem_data_b   (mem_data_b),
        .mac_clear    (mac_clear),
        .mac_valid    (mac_valid),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_result   (mac_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency memories
    always @(posedge clk) begin
        if (mem_rd_en) begin
            rdA <= memA[mem_addr_a];
            rdB <= memB[mem_addr_b];
        end
    end
    assign mem_data_a = rdA;
    assign mem_data_b = rdB;

    // One-cycle-latency accumulator
    always @(posedge clk) begin
        if (reset || mac_clear) acc <= '0;
        else if (mac_valid) acc <= acc + BW_ACC'(mac_a) * BW_ACC'(mac_b);
    end
    assign mac_result = acc;

    // Interface monitor, sampled just after each rising edge
    initial begin
        logic prevVld;
        prevVld = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rd_en === 1'b1) begin
                rdCnt++;
                addrQA.push_back(mem_addr_a);
                addrQB.push_back(mem_addr_b);
            end
            if (mac_valid === 1'b1) begin
                vldCnt++;
                if (!prevVld) vldRuns++;
            end
            prevVld = (mac_valid === 1'b1);
            if (mac_clear === 1'b1) clrCnt++;
            if (done === 1'b1) doneCnt++;
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a falling edge; starts one operation and checks everything about it
    task automatic runOp(input int len, input int bA, input int bB,
                         input bit pokeFetch, input bit pokeDone);
        longint sum;
        logic [63:0] expRes;
        int t0, dCyc, expLat, aOff, r0, v0, vr0, c0, d0, badA, badB;
        bit seen;
        sum = 0;
        for (int i = 0; i < len; i++)
            sum += longint'(memA[(bA + i) % DEPTH]) * longint'(memB[(bB + i) % DEPTH]);
        expRes = 64'(sum) & ((64'd1 << BW_ACC) - 64'd1);
        expLat = (len == 0) ? 3 : len + MEM_LAT + MAC_LAT + 4;
        aOff = addrQA.size();
        r0 = rdCnt; v0 = vldCnt; vr0 = vldRuns; c0 = clrCnt; d0 = doneCnt;
        vec_len     = LEN_W'(len);
        base_addr_a = ADDR_W'(bA);
        base_addr_b = ADDR_W'(bB);
        start = 1'b1;
        t0 = cyc;
        seen = 1'b0;
        dCyc = 0;
        for (int k = 0; k < len + 60 && !seen; k++) begin
            @(negedge clk);
            start       = pokeFetch && (cyc == t0 + 3);
            vec_len     = LEN_W'($urandom);
            base_addr_a = ADDR_W'($urandom);
            base_addr_b = ADDR_W'($urandom);
            if (done === 1'b1) begin
                seen = 1'b1;
                dCyc = cyc;
            end
        end
        checkVal("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            checkVal("done_latency", 64'(dCyc - t0), 64'(expLat));
            checkVal("result", 64'(result), expRes);
            checkVal("result_valid", 64'(result_valid), 64'd1);
            checkVal("busy_at_done", 64'(busy), 64'd0);
            checkVal("read_count", 64'(rdCnt - r0), 64'(len));
            checkVal("valid_count", 64'(vldCnt - v0), 64'(len));
            checkVal("valid_bursts", 64'(vldRuns - vr0), (len > 0) ? 64'd1 : 64'd0);
            checkVal("clear_count", 64'(clrCnt - c0), 64'd1);
            badA = 0;
            badB = 0;
            for (int i = 0; i < len; i++) begin
                if (aOff + i >= addrQA.size()) begin
                    badA++;
                    badB++;
                end else begin
                    if (len <= 8)
                        checkVal($sformatf("addr_a[%0d]", i), 64'(addrQA[aOff + i]), 64'((bA + i) % DEPTH));
                    if (int'(addrQA[aOff + i]) != (bA + i) % DEPTH) badA++;
                    if (int'(addrQB[aOff + i]) != (bB + i) % DEPTH) badB++;
                end
            end
            checkVal("addr_a_seq_errors", 64'(badA), 64'd0);
            checkVal("addr_b_seq_errors", 64'(badB), 64'd0);
            start = pokeDone;
            @(negedge clk);
            start = 1'b0;
            checkVal("done_width", 64'(done), 64'd0);
            checkVal("done_count", 64'(doneCnt - d0), 64'd1);
            checkVal("result_hold", 64'(result), expRes);
            if (pokeDone) checkVal("start_on_done_ignored", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int t0, v0;
        reset = 1'b1;
        start = 1'b0;
        vec_len = '0;
        base_addr_a = '0;
        base_addr_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            memA[i] = BW_A'($urandom);
            memB[i] = BW_B'($urandom);
        end
        repeat (3) @(negedge clk);
        checkVal("rst_busy", 64'(busy), 64'd0);
        checkVal("rst_done", 64'(done), 64'd0);
        checkVal("rst_result", 64'(result), 64'd0);
        checkVal("rst_result_valid", 64'(result_valid), 64'd0);
        checkVal("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        checkVal("rst_mac_valid", 64'(mac_valid), 64'd0);
        checkVal("rst_mac_clear", 64'(mac_clear), 64'd0);
        checkVal("rst_mac_a", 64'(mac_a), 64'd0);
        checkVal("rst_mac_b", 64'(mac_b), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkVal("idle_busy", 64'(busy), 64'd0);

        // Known vectors: 1*5+2*6+3*7+4*8
        for (int i = 0; i < 4; i++) begin
            memA[i]      = BW_A'(i + 1);
            memB[16 + i] = BW_B'(i + 5);
        end
        runOp(4, 0, 16, 1'b0, 1'b0);
        checkVal("known_dot_70", 64'(result), 64'd70);

        runOp(0, 7, 9, 1'b0, 1'b0);
        runOp(4, 510, 100, 1'b0, 1'b0);
        runOp(6, 33, 200, 1'b1, 1'b1);
        runOp(3, 300, 12, 1'b0, 1'b0);

        // Reset in the second fetch cycle
        vec_len = LEN_W'(6);
        base_addr_a = ADDR_W'(40);
        base_addr_b = ADDR_W'(80);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkVal("fetch_started", 64'(mem_rd_en), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkVal("mid_rst_cycle", 64'(cyc - t0), 64'd4);
        checkVal("mid_rst_busy", 64'(busy), 64'd0);
        checkVal("mid_rst_result", 64'(result), 64'd0);
        checkVal("mid_rst_result_valid", 64'(result_valid), 64'd0);
        v0 = vldCnt;
        repeat (8) @(negedge clk);
        checkVal("no_valid_after_rst", 64'(vldCnt - v0), 64'd0);
        runOp(2, 123, 456, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++)
            runOp($urandom_range(1, 40), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                  1'($urandom), 1'($urandom));

        // Longest vector with saturating operands
        for (int i = 0; i < DEPTH; i++) begin
            memA[i] = '1;
            memB[i] = '1;
        end
        runOp(511, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
